// File: rtl/alu_sequencer.sv
// Round-robin front end for the shared 16-bit ALU. It sequences the operand loads,
// the execute step and the result capture for whichever of the two clients holds the grant.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for a request; arbitration and operand latch
// S_LOAD_A  | ack to owner; A onto alu_data with enable_param_1
// S_LOAD_B  | B onto alu_data with enable_param_2 (skipped for NOT)
// S_EXEC    | opcode driven, enable_out high; ALU computes at cycle end
// S_CAPTURE | opcode still driven; alu_result sampled into result
// S_DONE    | one-cycle done (and err) pulse to the owner
module alu_sequencer #(
  parameter int          WIDTH      = 16,
  parameter logic [2:0]  ILLEGAL_OP = 3'b111
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] alu_data,
  output logic             alu_en_p1,
  output logic             alu_en_p2,
  output logic             alu_en_out,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [2:0] OP_NOT = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_CAPTURE, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;
  logic             r_last_grant;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;

  logic w_any_req;
  logic w_grant;
  logic w_illegal;

  assign w_any_req = req0 | req1;
  // On a tie the client that did not win last time goes next.
  assign w_grant   = (req0 & req1) ? ~r_last_grant : req1;
  assign w_illegal = (r_op == ILLEGAL_OP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any_req) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_op         <= w_grant ? op1 : op0;
        r_a          <= w_grant ? a1  : a0;
        r_b          <= w_grant ? b1  : b0;
      end
      if (r_state == S_CAPTURE) begin
        r_result <= alu_result;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    err        = 1'b0;
    alu_data   = '0;
    alu_en_p1  = 1'b0;
    alu_en_p2  = 1'b0;
    alu_en_out = 1'b0;
    alu_opcode = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        ack0 = ~r_owner;
        ack1 = r_owner;
        // An illegal opcode is bounced without ever touching the ALU.
        if (w_illegal) begin
          w_next = S_DONE;
        end else begin
          alu_data  = r_a;
          alu_en_p1 = 1'b1;
          w_next    = (r_op == OP_NOT) ? S_EXEC : S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        alu_data  = r_b;
        alu_en_p2 = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        alu_opcode = r_op;
        alu_en_out = 1'b1;
        w_next     = S_CAPTURE;
      end
      S_CAPTURE: begin
        alu_opcode = r_op;
        w_next     = S_DONE;
      end
      S_DONE: begin
        done0  = ~r_owner;
        done1  = r_owner;
        err    = w_illegal;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy   = (r_state != S_IDLE);
  assign result = r_result;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Two-requester controller that shares the 16-bit ALU (param_1/param_2/out registers, 3-bit opcode) between clients. It arbitrates round-robin, then sequences the ALU operand loads over the shared data input. It pulses the enables, captures the result and returns it to the granted client with a done pulse. It owns the ALU's data_in, enable_param_1, enable_param_2, enable_out and opcode inputs.

Parameters:
WIDTH, 16, datapath width; must match ALU width
ILLEGAL_OP, 3'b111, opcode rejected without touching the ALU

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; all state cleared immediately
req0  in  1  client 0 request, level, held until done0
op0  in  3  client 0 opcode (ALU encoding: 000 add … 110 xnor)
a0  in  WIDTH  client 0 operand A
b0  in  WIDTH  client 0 operand B
req1, op1, a1, b1  in  1/3/WIDTH/WIDTH  client 1, same meaning
ack0, ack1  out  1  one-cycle grant pulse; operands latched that edge
done0, done1  out  1  one-cycle completion pulse to the owner
err  out  1  valid with done; 1 = ILLEGAL_OP rejected
result  out  WIDTH  last captured ALU result, held until next capture
busy  out  1  high in any state other than IDLE
alu_data  out  WIDTH  drives ALU data_in
alu_en_p1  out  1  drives ALU enable_param_1
alu_en_p2  out  1  drives ALU enable_param_2
alu_en_out  out  1  drives ALU enable_out
alu_opcode  out  3  drives ALU opcode
alu_result  in  WIDTH  ALU alu_out; Z except after an EXEC edge

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant=1, so client 0 wins the first tie.
- All outputs are registered or decoded from state only. There is no combinational path from req*/a*/b* to alu_*.
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, DONE.
- IDLE: if any req is high, grant one client. The ack for that client pulses in the next cycle. Latch op/a/b/owner and set last_grant=owner.
  - Next state is LOAD_A.
  - If the latched op == ILLEGAL_OP, next state is DONE with err=1; result is unchanged and no alu_en_* is asserted.
- Arbitration: only one req high -> that client wins. Both high -> the client != last_grant wins.
- LOAD_A: alu_data=A, alu_en_p1=1. Next state is LOAD_B, or EXEC if op==010 (NOT, single operand).
- LOAD_B: alu_data=B, alu_en_p2=1. Next state is EXEC.
- EXEC: alu_opcode=op, alu_en_out=1, alu_data=0. The ALU computes at the end-of-cycle edge. Next state is CAPTURE.
- CAPTURE: alu_opcode is still driven; alu_en_out=0. Sample alu_result into result at the end of this cycle; the ALU then returns to Z. Next state is DONE.
- DONE: done<owner>=1 for exactly one cycle; err is valid; then IDLE. A req still high in IDLE the next cycle starts a new operation, with no bubble beyond IDLE.
- Outside the load states: alu_data=0 and alu_en_p1/alu_en_p2=0. alu_opcode=0 outside EXEC/CAPTURE.
- Latency, counted from the request-sampled edge to the done cycle: 5 cycles for binary ops, 4 for NOT, 2 for ILLEGAL_OP.
- Throughput: one operation per 6/5/3 cycles respectively.
- Width: the result is the ALU's WIDTH-bit value unchanged, modulo 2^WIDTH. The sequencer does no arithmetic.
- Operands are latched at grant. Changes to a*/b*/op* afterwards are ignored.
- Owner drops req mid-operation: the operation completes and done still pulses.
- The non-owner's req is ignored until the next IDLE.
- Reset mid-operation: return to IDLE immediately and drop all enables. No done pulse; the operation is discarded and the client must re-request.
- The ALU's own synchronous reset is separate. After a controller reset the ALU param registers may hold stale data; this is harmless because every operation reloads them.

Test Plan:
- req0 op=000 a=0x1234 b=0x0FFF -> ack0 next cycle; alu_en_p1, en_p2, en_out asserted in successive cycles. done0 5 cycles after the request edge, result=0x2233, err=0.
- req1 op=001 a=0x0000 b=0x0001 -> result=0xFFFF (wrap) on done1; done0 stays 0.
- req0 op=010 a=0x00FF -> LOAD_B skipped (alu_en_p2 never high); done0 after 4 cycles; result=0xFF00.
- req0 and req1 held high after reset, both op=000 -> grants alternate 0,1,0,1. Each done goes to the correct client, with no overlapping alu_en_*.
- req0 op=111 -> done0 after 2 cycles with err=1, no alu_en_* pulse, result unchanged from the previous value.
- reset asserted during EXEC, then req1 op=100 a=0xF0F0 b=0x0F0F -> no done pulses during reset. All alu_* go to 0 asynchronously; the next operation returns result=0xFFFF on done1.
